// File: rtl/ifetch_prefetch_pkg.sv
// Shared definitions for the instruction-fetch unit: controller states,
// exception cause codes and Wishbone byte-select constants.
package ifetch_prefetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } fetch_state_e;

   localparam logic [1:0] EXC_MISALIGN = 2'd0;
   localparam logic [1:0] EXC_FAULT    = 2'd1;

   localparam logic [3:0] SEL_WORD = 4'hF;
   localparam logic [3:0] SEL_NONE = 4'h0;

   function automatic logic misaligned(input logic [1:0] lsb);
      return |lsb;
   endfunction

endpackage

// File: rtl/ifetch_prefetch_sync_fifo.sv
// Synchronous FIFO with occupancy count and a flush that empties the queue
// while still accepting a push in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   assign rdata = mem[rptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Pointer and occupancy update; a push coinciding with flush lands in slot 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= push ? AW'(1) : '0;
         count <= push ? CW'(1) : '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (rst && push) mem[flush ? '0 : wptr] <= wdata;
   end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch unit: Wishbone classic master feeding a prefetch FIFO of
// {pc, instr, exc, cause}. Handles redirect/flush, in-flight response drain,
// bus-error and misaligned-target exceptions delivered in order.
module ifetch_prefetch
   import ifetch_prefetch_pkg::*;
#(
   parameter int unsigned    XLEN       = 32,
   parameter int unsigned    DEPTH      = 4,
   parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            exc_o,
   output logic [1:0]      exc_cause_o,
   output logic [XLEN-1:0] iaddr_o,
   input  logic [31:0]     idat_i,
   output logic [3:0]      isel_o,
   output logic            icyc_o,
   output logic            istb_o,
   output logic            iwe_o,
   input  logic            iack_i,
   input  logic            ierr_i
);

   localparam int unsigned WIDTH = XLEN + 32 + 3;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   fetch_state_e    state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] pc_step;
   logic            active;

   logic            pop;
   logic            resp;
   logic            busy;
   logic [CW-1:0]   count;
   logic [CW-1:0]   occ;
   logic            full;
   logic            empty;

   logic            push;
   logic [XLEN-1:0] push_pc;
   logic [31:0]     push_instr;
   logic            push_exc;
   logic [1:0]      push_cause;
   logic [WIDTH-1:0] head;

   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_instr;
   logic            head_exc;
   logic [1:0]      head_cause;

   assign pop     = instr_valid_o & instr_ready_i;
   assign resp    = iack_i | ierr_i;
   assign busy    = ((state == S_FETCH) || (state == S_DRAIN)) && !resp;
   assign occ     = count - CW'(pop);
   assign pc_step = fetch_pc + XLEN'(4);

   assign {head_pc, head_instr, head_exc, head_cause} = head;

   assign instr_valid_o = !empty;
   assign instr_o       = instr_valid_o ? head_instr : '0;
   assign instr_pc_o    = instr_valid_o ? head_pc    : '0;
   assign exc_o         = instr_valid_o & head_exc;
   assign exc_cause_o   = instr_valid_o ? head_cause : '0;

   assign icyc_o = active;
   assign istb_o = active;
   assign iwe_o  = 1'b0;

   sync_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .flush(redirect_i),
      .push (push),
      .wdata({push_pc, push_instr, push_exc, push_cause}),
      .pop  (pop),
      .rdata(head),
      .count(count),
      .full (full),
      .empty(empty)
   );

   // Select what (if anything) enters the FIFO this cycle; a redirect suppresses
   // any bus response, and a misaligned target raises its exception immediately
   // when no bus cycle is outstanding
   always_comb begin
      push       = 1'b0;
      push_pc    = fetch_pc;
      push_instr = '0;
      push_exc   = 1'b0;
      push_cause = EXC_MISALIGN;
      if (redirect_i) begin
         if (!busy && misaligned(redirect_pc_i[1:0])) begin
            push     = 1'b1;
            push_pc  = redirect_pc_i;
            push_exc = 1'b1;
         end
      end else begin
         case (state)
            S_FETCH: begin
               if (ierr_i) begin
                  push       = 1'b1;
                  push_exc   = 1'b1;
                  push_cause = EXC_FAULT;
               end else if (iack_i) begin
                  push       = 1'b1;
                  push_instr = idat_i;
               end
            end
            S_DRAIN: begin
               if (resp && misaligned(fetch_pc[1:0])) begin
                  push     = 1'b1;
                  push_exc = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Fetch controller: PC counter, state and registered Wishbone outputs.
   // A misaligned redirect arriving while a cycle is outstanding drains first
   // and raises the exception once the bus is free.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_ADDR;
         active   <= 1'b0;
         iaddr_o  <= '0;
         isel_o   <= SEL_NONE;
      end else if (redirect_i) begin
         fetch_pc <= redirect_pc_i;
         if (busy) begin
            state <= S_DRAIN;
         end else if (misaligned(redirect_pc_i[1:0])) begin
            state   <= S_HALT;
            active  <= 1'b0;
            iaddr_o <= '0;
            isel_o  <= SEL_NONE;
         end else begin
            state   <= S_FETCH;
            active  <= 1'b1;
            iaddr_o <= redirect_pc_i;
            isel_o  <= SEL_WORD;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (!full || pop) begin
                  state   <= S_FETCH;
                  active  <= 1'b1;
                  iaddr_o <= {fetch_pc[XLEN-1:2], 2'b00};
                  isel_o  <= SEL_WORD;
               end
            end
            S_FETCH: begin
               if (ierr_i) begin
                  state   <= S_HALT;
                  active  <= 1'b0;
                  iaddr_o <= '0;
                  isel_o  <= SEL_NONE;
               end else if (iack_i) begin
                  fetch_pc <= pc_step;
                  if (occ < CW'(DEPTH - 1)) begin
                     iaddr_o <= pc_step;
                  end else begin
                     state   <= S_IDLE;
                     active  <= 1'b0;
                     iaddr_o <= '0;
                     isel_o  <= SEL_NONE;
                  end
               end
            end
            S_DRAIN: begin
               if (resp) begin
                  if (misaligned(fetch_pc[1:0])) begin
                     state   <= S_HALT;
                     active  <= 1'b0;
                     iaddr_o <= '0;
                     isel_o  <= SEL_NONE;
                  end else begin
                     state   <= S_FETCH;
                     iaddr_o <= fetch_pc;
                  end
               end
            end
            S_HALT: ;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: a cycle-by-cycle vector table plus
// hand-written sequences for FIFO fill, redirect drain and reset mid-cycle.
module tb_ifetch_prefetch;

   typedef struct packed {
      logic        valid;
      logic        exc;
      logic [1:0]  cause;
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] pc;
      logic [31:0] instr;
   } obs_t;

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        ack;
      logic        err;
      logic [31:0] dat;
      obs_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        exc_o;
   logic [1:0]  exc_cause_o;
   logic [31:0] iaddr_o;
   logic [31:0] idat_i = '0;
   logic [3:0]  isel_o;
   logic        icyc_o;
   logic        istb_o;
   logic        iwe_o;
   logic        iack_i = 1'b0;
   logic        ierr_i = 1'b0;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   vec_t tbl [26];

   always #5 clk = ~clk;

   ifetch_prefetch #(
      .XLEN      (32),
      .DEPTH     (4),
      .RESET_ADDR(32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i),
      .instr_o      (instr_o),
      .instr_pc_o   (instr_pc_o),
      .exc_o        (exc_o),
      .exc_cause_o  (exc_cause_o),
      .iaddr_o      (iaddr_o),
      .idat_i       (idat_i),
      .isel_o       (isel_o),
      .icyc_o       (icyc_o),
      .istb_o       (istb_o),
      .iwe_o        (iwe_o),
      .iack_i       (iack_i),
      .ierr_i       (ierr_i)
   );

   function automatic obs_t mk(input logic v, input logic e, input logic [1:0] c,
                               input logic s, input logic [31:0] a,
                               input logic [31:0] p, input logic [31:0] d);
      obs_t o;
      o.valid = v;
      o.exc   = e;
      o.cause = c;
      o.cyc   = s;
      o.stb   = s;
      o.we    = 1'b0;
      o.sel   = s ? 4'hF : 4'h0;
      o.addr  = a;
      o.pc    = p;
      o.instr = d;
      return o;
   endfunction

   function automatic vec_t vec(input logic r, input logic rd, input logic [31:0] rp,
                                input logic rdy, input logic ak, input logic er,
                                input logic [31:0] d, input obs_t e);
      vec_t t;
      t.rst = r; t.redir = rd; t.rpc = rp; t.ready = rdy;
      t.ack = ak; t.err = er; t.dat = d; t.exp = e;
      return t;
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o.valid = instr_valid_o;
      o.exc   = exc_o;
      o.cause = exc_cause_o;
      o.cyc   = icyc_o;
      o.stb   = istb_o;
      o.we    = iwe_o;
      o.sel   = isel_o;
      o.addr  = iaddr_o;
      o.pc    = instr_pc_o;
      o.instr = instr_o;
      return o;
   endfunction

   task automatic step(input logic r, input logic rd, input logic [31:0] rp,
                       input logic rdy, input logic ak, input logic er,
                       input logic [31:0] d);
      rst           = r;
      redirect_i    = rd;
      redirect_pc_i = rp;
      instr_ready_i = rdy;
      iack_i        = ak;
      ierr_i        = er;
      idat_i        = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_obs(input string name, input obs_t exp);
      obs_t act;
      act = get_obs();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (valid exc cause cyc stb we sel addr pc instr)",
                  name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   initial begin
      // rst redir rpc ready ack err dat -> expected after the edge
      for (int i = 0; i < 5; i++)
         tbl[i] = vec(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      tbl[5]  = vec(1, 0, 0, 0, 0, 0, 0,             mk(0, 0, 0, 1, 32'h0, 0, 0));
      tbl[6]  = vec(1, 0, 0, 0, 1, 0, 32'h11111111,  mk(1, 0, 0, 1, 32'h4, 32'h0, 32'h11111111));
      tbl[7]  = vec(1, 0, 0, 0, 0, 0, 0,             mk(1, 0, 0, 1, 32'h4, 32'h0, 32'h11111111));
      tbl[8]  = vec(1, 0, 0, 0, 1, 0, 32'h23647862,  mk(1, 0, 0, 1, 32'h8, 32'h0, 32'h11111111));
      tbl[9]  = vec(1, 0, 0, 1, 0, 0, 0,             mk(1, 0, 0, 1, 32'h8, 32'h4, 32'h23647862));
      tbl[10] = vec(1, 0, 0, 1, 0, 0, 0,             mk(0, 0, 0, 1, 32'h8, 0, 0));
      tbl[11] = vec(1, 0, 0, 0, 1, 0, 32'hA5A5A5A5,  mk(1, 0, 0, 1, 32'hC, 32'h8, 32'hA5A5A5A5));
      tbl[12] = vec(1, 0, 0, 0, 0, 1, 0,             mk(1, 0, 0, 0, 0, 32'h8, 32'hA5A5A5A5));
      tbl[13] = vec(1, 0, 0, 1, 0, 0, 0,             mk(1, 1, 1, 0, 0, 32'hC, 0));
      tbl[14] = vec(1, 0, 0, 0, 0, 0, 0,             mk(1, 1, 1, 0, 0, 32'hC, 0));
      tbl[15] = vec(1, 0, 0, 0, 0, 0, 0,             mk(1, 1, 1, 0, 0, 32'hC, 0));
      tbl[16] = vec(1, 0, 0, 1, 0, 0, 0,             mk(0, 0, 0, 0, 0, 0, 0));
      tbl[17] = vec(1, 1, 32'h2, 0, 0, 0, 0,         mk(1, 1, 0, 0, 0, 32'h2, 0));
      tbl[18] = vec(1, 0, 0, 0, 0, 0, 0,             mk(1, 1, 0, 0, 0, 32'h2, 0));
      tbl[19] = vec(1, 1, 32'h100, 0, 0, 0, 0,       mk(0, 0, 0, 1, 32'h100, 0, 0));
      tbl[20] = vec(1, 0, 0, 0, 0, 0, 0,             mk(0, 0, 0, 1, 32'h100, 0, 0));
      tbl[21] = vec(1, 0, 0, 0, 1, 0, 32'hDEADBEEF,  mk(1, 0, 0, 1, 32'h104, 32'h100, 32'hDEADBEEF));
      tbl[22] = vec(1, 1, 32'hFFFFFFFC, 0, 0, 0, 0,  mk(0, 0, 0, 1, 32'h104, 0, 0));
      tbl[23] = vec(1, 0, 0, 0, 1, 0, 32'h12345678,  mk(0, 0, 0, 1, 32'hFFFFFFFC, 0, 0));
      tbl[24] = vec(1, 0, 0, 0, 1, 0, 32'hCAFEF00D,  mk(1, 0, 0, 1, 32'h0, 32'hFFFFFFFC, 32'hCAFEF00D));
      tbl[25] = vec(1, 1, 32'h40, 0, 1, 0, 32'h99999999, mk(0, 0, 0, 1, 32'h40, 0, 0));

      for (int i = 0; i < 26; i++) begin
         step(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].ready,
              tbl[i].ack, tbl[i].err, tbl[i].dat);
         check_obs($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Fill: no consumer, every request acked -> exactly DEPTH entries
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check_obs("fill_start", mk(0, 0, 0, 1, 32'h0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         if (i > 0) check_obs($sformatf("fill_req%0d", i), mk(1, 0, 0, 1, 32'(4 * i), 0, 32'h100));
         step(1, 0, 0, 0, 1, 0, 32'(32'h100 + i));
      end
      check_obs("fill_full", mk(1, 0, 0, 0, 0, 0, 32'h100));
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         check_obs($sformatf("fill_hold%0d", i), mk(1, 0, 0, 0, 0, 0, 32'h100));
      end
      step(1, 0, 0, 1, 0, 0, 0);
      check_obs("fill_one_req", mk(1, 0, 0, 1, 32'h10, 32'h4, 32'h101));
      step(1, 0, 0, 0, 0, 0, 0);
      check_obs("fill_wait", mk(1, 0, 0, 1, 32'h10, 32'h4, 32'h101));
      step(1, 0, 0, 0, 1, 0, 32'h104);
      check_obs("fill_refull", mk(1, 0, 0, 0, 0, 32'h4, 32'h101));
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         check_obs($sformatf("fill_stay%0d", i), mk(1, 0, 0, 0, 0, 32'h4, 32'h101));
      end
      step(1, 0, 0, 1, 0, 0, 0);
      check_obs("fill_pop1", mk(1, 0, 0, 1, 32'h14, 32'h8, 32'h102));
      step(1, 0, 0, 1, 0, 0, 0);
      check_obs("fill_pop2", mk(1, 0, 0, 1, 32'h14, 32'hC, 32'h103));
      step(1, 0, 0, 1, 0, 0, 0);
      check_obs("fill_pop3", mk(1, 0, 0, 1, 32'h14, 32'h10, 32'h104));
      step(1, 0, 0, 1, 0, 0, 0);
      check_obs("fill_empty", mk(0, 0, 0, 1, 32'h14, 0, 0));

      // Reset while a request is outstanding and acked on the same edge
      step(0, 0, 0, 0, 1, 0, 32'h55555555);
      check_obs("rst_mid", mk(0, 0, 0, 0, 0, 0, 0));
      step(1, 0, 0, 0, 0, 0, 0);
      check_obs("rst_release", mk(0, 0, 0, 1, 32'h0, 0, 0));

      // Redirect while the request to 8 is in flight: its data is discarded
      step(1, 0, 0, 0, 1, 0, 32'hA0);
      step(1, 0, 0, 0, 1, 0, 32'hA4);
      check_obs("drn_req8", mk(1, 0, 0, 1, 32'h8, 32'h0, 32'hA0));
      step(1, 1, 32'h40, 0, 0, 0, 0);
      check_obs("drn_hold", mk(0, 0, 0, 1, 32'h8, 0, 0));
      step(1, 0, 0, 0, 1, 0, 32'h88888888);
      check_obs("drn_next40", mk(0, 0, 0, 1, 32'h40, 0, 0));
      step(1, 0, 0, 0, 1, 0, 32'h40404040);
      check_obs("drn_data40", mk(1, 0, 0, 1, 32'h44, 32'h40, 32'h40404040));

      // Two redirects while draining: the latest target wins, one drain only
      step(1, 1, 32'h60, 0, 0, 0, 0);
      check_obs("drn2_first", mk(0, 0, 0, 1, 32'h44, 0, 0));
      step(1, 1, 32'h70, 0, 0, 0, 0);
      check_obs("drn2_second", mk(0, 0, 0, 1, 32'h44, 0, 0));
      step(1, 0, 0, 0, 1, 0, 32'h44444444);
      check_obs("drn2_next70", mk(0, 0, 0, 1, 32'h70, 0, 0));
      step(1, 0, 0, 0, 1, 0, 32'h70707070);
      check_obs("drn2_data70", mk(1, 0, 0, 1, 32'h74, 32'h70, 32'h70707070));

      // Redirect together with a pop: flush wins, bus drains toward 200
      step(1, 1, 32'h200, 1, 0, 0, 0);
      check_obs("rdpop_flush", mk(0, 0, 0, 1, 32'h74, 0, 0));
      step(1, 0, 0, 0, 1, 0, 32'h74747474);
      check_obs("rdpop_next", mk(0, 0, 0, 1, 32'h200, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
